// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Holds arbiter state and owner encodings plus the default access latency.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam int LAT_DEFAULT = 4;
    localparam int CW_DEFAULT  = 4;

endpackage

// File: rtl/dmem_arbiter_lat_counter.sv
// Loadable down-counter that times one memory access.
// Ports: clk, rst (sync, active-low), load/load_val, dec, cnt, zero flag.
module arb_lat_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one fixed-latency single-port memory between IF and DM.
// Ports: clk, rst (sync, active-low); IF req/addr -> rdata/done/stall;
// DM req/wr/addr/wdata/dump -> rdata/done/stall; mem_* to memory model.
// Optional: define DMEM_ARB_RR_EN for round-robin priority (default DM-first).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LAT = LAT_DEFAULT,
    parameter int CW  = CW_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_req,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic        dm_dump,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_dump,
    input  logic [15:0] mem_rdata
);

    arb_state_t  state, state_n;
    arb_owner_t  owner;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        wr_q;
    logic        load;
    logic        dec;
    logic        cnt_zero;
    logic [CW-1:0] cnt;
    logic        idle;
    logic        if_elig;
    logic        dm_elig;
    logic        grant_dm;
    logic        grant_if;

    arb_lat_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (CW'(LAT - 1)),
        .dec      (dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // A requester whose done is high this cycle is not eligible,
    // so a held req is never regranted on its own done cycle.
    assign idle    = (state == ARB_IDLE);
    assign if_elig = if_req & ~if_done;
    assign dm_elig = dm_req & ~dm_done;

`ifdef DMEM_ARB_RR_EN
    arb_owner_t last_owner;

    assign grant_dm = idle & dm_elig &
                      (~if_elig | (last_owner == OWN_IF));

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner <= OWN_IF;
        end else if (grant_dm) begin
            last_owner <= OWN_DM;
        end else if (grant_if) begin
            last_owner <= OWN_IF;
        end
    end
`else
    assign grant_dm = idle & dm_elig;
`endif

    assign grant_if = idle & if_elig & ~grant_dm;

    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    always_comb begin
        state_n   = state;
        load      = 1'b0;
        dec       = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'h0000;
        mem_wdata = 16'h0000;
        mem_dump  = 1'b0;
        unique case (state)
            ARB_IDLE: begin
                mem_dump = dm_dump;
                if (grant_dm | grant_if) begin
                    state_n = ARB_BUSY;
                    load    = 1'b1;
                end
            end
            ARB_BUSY: begin
                mem_en    = 1'b1;
                mem_wr    = wr_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (cnt_zero) begin
                    state_n = ARB_IDLE;
                end else begin
                    dec = 1'b1;
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ARB_IDLE;
            owner    <= OWN_IF;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            wr_q     <= 1'b0;
            if_rdata <= 16'h0000;
            dm_rdata <= 16'h0000;
            if_done  <= 1'b0;
            dm_done  <= 1'b0;
        end else begin
            state   <= state_n;
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if (grant_dm) begin
                owner   <= OWN_DM;
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
                wr_q    <= dm_wr;
            end else if (grant_if) begin
                owner   <= OWN_IF;
                addr_q  <= if_addr;
                wdata_q <= 16'h0000;
                wr_q    <= 1'b0;
            end
            if (!idle && cnt_zero) begin
                if (owner == OWN_DM) begin
                    dm_done <= 1'b1;
                    if (!wr_q) begin
                        dm_rdata <= mem_rdata;
                    end
                end else begin
                    if_done  <= 1'b1;
                    if_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// Instances: dut (LAT=4, array memory) and dut1 (LAT=1, address-derived data).
module tb_dmem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req, dm_req, dm_wr, dm_dump;
    logic [15:0] if_addr, dm_addr, dm_wdata;
    logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_done, if_stall, dm_done, dm_stall;
    logic        mem_en, mem_wr, mem_dump;

    logic        l1_if_req, l1_dm_req, l1_dm_dump;
    logic [15:0] l1_if_addr, l1_dm_addr;
    logic [15:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr;
    logic [15:0] l1_mem_wdata, l1_mem_rdata;
    logic        l1_if_done, l1_if_stall, l1_dm_done, l1_dm_stall;
    logic        l1_mem_en, l1_mem_wr, l1_mem_dump;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.LAT(4), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_done(if_done), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_dump(dm_dump), .dm_rdata(dm_rdata),
        .dm_done(dm_done), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_dump(mem_dump),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.LAT(1), .CW(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(l1_if_req), .if_addr(l1_if_addr),
        .if_rdata(l1_if_rdata), .if_done(l1_if_done),
        .if_stall(l1_if_stall),
        .dm_req(l1_dm_req), .dm_wr(1'b0), .dm_addr(l1_dm_addr),
        .dm_wdata(16'h0000), .dm_dump(l1_dm_dump),
        .dm_rdata(l1_dm_rdata), .dm_done(l1_dm_done),
        .dm_stall(l1_dm_stall),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr),
        .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_dump(l1_mem_dump), .mem_rdata(l1_mem_rdata)
    );

    assign mem_rdata    = mem[mem_addr];
    assign l1_mem_rdata = l1_mem_addr ^ 16'hA5A5;

    always @(posedge clk) begin
        if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [52:0] obs;
        rst = 1'b0;
        if_req = 0; dm_req = 0; dm_wr = 0; dm_dump = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        l1_if_req = 0; l1_dm_req = 0; l1_dm_dump = 0;
        l1_if_addr = 0; l1_dm_addr = 0;
        step();
        step();
        obs = {if_rdata, dm_rdata, mem_addr, if_done, dm_done,
               mem_en, mem_wr, mem_dump};
        checks++;
        if (obs !== 53'd0) begin
            errors++;
            $display("FAIL reset outputs got %h want 0", obs);
        end
        checks++;
        if ({l1_mem_en, l1_dm_done, l1_if_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_l1 got %b want 000",
                     {l1_mem_en, l1_dm_done, l1_if_done});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_read();
        logic [18:0] obs, exp;
        if_addr = 16'h0040;
        if_req  = 1'b1;
        #1;
        checks++;
        if ({if_stall, mem_en} !== 2'b10) begin
            errors++;
            $display("FAIL read_c0 got %b want 10", {if_stall, mem_en});
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            obs = {mem_en, mem_addr, if_done, if_stall};
            exp = (k < 5) ? {1'b1, 16'h0040, 1'b0, 1'b1}
                          : {1'b0, 16'h0000, 1'b1, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL read_c%0d got %h want %h", k, obs, exp);
            end
        end
        checks++;
        if (if_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL read_data got %h want 1234", if_rdata);
        end
        if_req = 1'b0;
        step();
        checks++;
        if ({if_done, mem_en, if_rdata} !== {2'b00, 16'h1234}) begin
            errors++;
            $display("FAIL read_after got %b %b %h want 0 0 1234",
                     if_done, mem_en, if_rdata);
        end
    endtask

    task automatic test_collision();
        logic [20:0] obs, exp;
        dm_wr = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
        if_addr = 16'h0040;
        dm_req = 1'b1; if_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            obs = {mem_en, mem_wr, mem_addr, dm_done, if_done, dm_stall};
            if (k < 5)       exp = {2'b11, 16'h0010, 3'b001};
            else if (k == 5) exp = {2'b00, 16'h0000, 3'b100};
            else if (k < 10) exp = {2'b10, 16'h0040, 3'b000};
            else             exp = {2'b00, 16'h0000, 3'b010};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL coll_c%0d got %h want %h", k, obs, exp);
            end
            if (k == 5) dm_req = 1'b0;
        end
        checks++;
        if (if_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL coll_ifdata got %h want 1234", if_rdata);
        end
        if_req = 1'b0;
        dm_wr = 1'b0;
        dm_wdata = 16'h0000;
        step();
        dm_req = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        checks++;
        if ({dm_done, dm_rdata} !== {1'b1, 16'hBEEF}) begin
            errors++;
            $display("FAIL coll_readback got %b %h want 1 beef",
                     dm_done, dm_rdata);
        end
        dm_req = 1'b0;
        step();
    endtask

    task automatic test_early_drop();
        logic [1:0] exp;
        dm_wr = 1'b0; dm_addr = 16'h0040; dm_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            exp = {(k <= 4), (k == 5)};
            checks++;
            if ({mem_en, dm_done} !== exp) begin
                errors++;
                $display("FAIL drop_c%0d got %b want %b",
                         k, {mem_en, dm_done}, exp);
            end
            if (k == 2) dm_req = 1'b0;
        end
        checks++;
        if (dm_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL drop_data got %h want 1234", dm_rdata);
        end
    endtask

    task automatic test_reset_mid();
        logic [52:0] obs;
        logic [1:0]  exp;
        dm_wr = 1'b0; dm_addr = 16'h0010; dm_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (mem_en !== 1'b1) begin
                errors++;
                $display("FAIL rmid_busy%0d got %b want 1", k, mem_en);
            end
        end
        rst = 1'b0;
        step();
        obs = {if_rdata, dm_rdata, mem_addr, if_done, dm_done,
               mem_en, mem_wr, mem_dump};
        checks++;
        if (obs !== 53'd0) begin
            errors++;
            $display("FAIL rmid_abort got %h want 0", obs);
        end
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            exp = {(k <= 4), (k == 5)};
            checks++;
            if ({mem_en, dm_done} !== exp) begin
                errors++;
                $display("FAIL rmid_c%0d got %b want %b",
                         k, {mem_en, dm_done}, exp);
            end
        end
        checks++;
        if (dm_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL rmid_data got %h want beef", dm_rdata);
        end
        dm_req = 1'b0;
        step();
    endtask

    task automatic test_lat1_interleave();
        logic [2:0] exp;
        l1_dm_addr = 16'h0003; l1_if_addr = 16'h0007;
        l1_dm_req = 1'b1; l1_if_req = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = {(k % 2 == 1), (k == 2 || k == 6), (k == 4)};
            checks++;
            if ({l1_mem_en, l1_dm_done, l1_if_done} !== exp) begin
                errors++;
                $display("FAIL l1_c%0d got %b want %b", k,
                         {l1_mem_en, l1_dm_done, l1_if_done}, exp);
            end
            if (k == 4) begin
                checks++;
                if ({l1_dm_rdata, l1_if_rdata} !== 32'hA5A6_A5A2) begin
                    errors++;
                    $display("FAIL l1_data got %h %h want a5a6 a5a2",
                             l1_dm_rdata, l1_if_rdata);
                end
            end
        end
        l1_dm_req = 1'b0; l1_if_req = 1'b0;
        step();
        checks++;
        if (l1_mem_en !== 1'b0) begin
            errors++;
            $display("FAIL l1_end got %b want 0", l1_mem_en);
        end
    endtask

    task automatic test_dump();
        l1_dm_dump = 1'b1;
        #1;
        checks++;
        if (l1_mem_dump !== 1'b1) begin
            errors++;
            $display("FAIL dump_idle got %b want 1", l1_mem_dump);
        end
        l1_dm_dump = 1'b0;
        l1_dm_addr = 16'h0003;
        l1_dm_req = 1'b1;
        step();
        l1_dm_dump = 1'b1;
        #1;
        checks++;
        if ({l1_mem_en, l1_mem_dump} !== 2'b10) begin
            errors++;
            $display("FAIL dump_busy got %b want 10",
                     {l1_mem_en, l1_mem_dump});
        end
        step();
        checks++;
        if ({l1_dm_done, l1_mem_dump} !== 2'b11) begin
            errors++;
            $display("FAIL dump_done got %b want 11",
                     {l1_dm_done, l1_mem_dump});
        end
        l1_dm_req = 1'b0; l1_dm_dump = 1'b0;
        step();
    endtask

`ifdef DMEM_ARB_RR_EN
    task automatic rr_collision(input logic [15:0] first,
                                input logic [15:0] second);
        dm_wr = 1'b0; dm_addr = 16'h0010; if_addr = 16'h0040;
        dm_req = 1'b1; if_req = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 1 || k == 6) begin
                checks++;
                if (mem_addr !== ((k == 1) ? first : second)) begin
                    errors++;
                    $display("FAIL rr_grant%0d got %h want %h", k,
                             mem_addr, (k == 1) ? first : second);
                end
            end
            if (dm_done) dm_req = 1'b0;
            if (if_done) if_req = 1'b0;
        end
        step();
    endtask

    task automatic test_round_robin();
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        rr_collision(16'h0010, 16'h0040);
        dm_addr = 16'h0010; dm_req = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        dm_req = 1'b0;
        step();
        rr_collision(16'h0040, 16'h0010);
    endtask
`endif

    initial begin
        mem[16'h0040] = 16'h1234;
        mem[16'h0010] = 16'h0000;
        test_reset();
        test_basic_read();
        test_collision();
        test_early_drop();
        test_reset_mid();
        test_lat1_interleave();
        test_dump();
`ifdef DMEM_ARB_RR_EN
        test_round_robin();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
